// File: rtl/arb_16_enc.sv
// arb_16_enc: 16-requester grant arbiter with a hold-time limit.
// A grant is held until the holder pulses fim, drops its request, or the hold
// counter reaches MAX_CICLOS-1. The timeout output pulses only when the counter
// limit alone caused the release. At least one idle (LIVRE) cycle always
// separates two consecutive grants.
// Optional feature macro ROUND_ROBIN_EN: rotates the search start index to one
// below the last granted index. Without it the arbiter is strict priority,
// where the highest set index wins.
module arb_16_enc #(
  parameter int unsigned MAX_CICLOS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic        fim,
  output logic [15:0] gnt,
  output logic [3:0]  gnt_id,
  output logic        gnt_valid,
  output logic        timeout
);

  localparam logic [0:0] LIVRE     = 1'b0;
  localparam logic [0:0] CONCEDIDO = 1'b1;

  // Counter value on the last cycle a grant may be held.
  localparam logic [7:0] LIMIT = 8'(MAX_CICLOS - 1);

  logic [0:0] state;
  logic [7:0] hold_cnt;
  logic [3:0] start_idx;
  logic [3:0] winner;
  logic       any_req;
  logic       holder_req;
  logic       at_limit;
  logic       release_now;
  logic       forced;

  // Descending search from s, wrapping 0 -> 15. The loop runs from the
  // farthest offset to the nearest, so the nearest set bit is written last
  // and therefore wins.
  function automatic logic [3:0] pick(input logic [15:0] r, input logic [3:0] s);
    logic [3:0] idx;
    logic [3:0] best;
    best = s;
    for (int k = 15; k >= 0; k--) begin
      idx = s - 4'(k);
      if (r[idx]) best = idx;
    end
    return best;
  endfunction

`ifdef ROUND_ROBIN_EN
  logic [3:0] ultimo;

  // Remember the index of each new grant so the next search starts just below it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ultimo <= 4'd0;
    end else if (state == LIVRE && any_req) begin
      ultimo <= winner;
    end
  end

  assign start_idx = ultimo - 4'd1;
`else
  assign start_idx = 4'hF;
`endif

  // Winner selection and release decode.
  always_comb begin
    any_req     = |req;
    winner      = pick(req, start_idx);
    holder_req  = req[gnt_id];
    at_limit    = (hold_cnt == LIMIT);
    release_now = fim | ~holder_req | at_limit;
    // fim or a dropped request on the limit cycle suppresses the timeout pulse.
    forced      = at_limit & ~fim & holder_req;
  end

  // Two-state grant FSM with registered outputs and hold counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LIVRE;
      gnt       <= 16'h0000;
      gnt_id    <= 4'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      hold_cnt  <= 8'd0;
    end else if (state == LIVRE) begin
      timeout  <= 1'b0;
      hold_cnt <= 8'd0;
      if (any_req) begin
        gnt       <= 16'(1) << winner;
        gnt_id    <= winner;
        gnt_valid <= 1'b1;
        state     <= CONCEDIDO;
      end
    end else begin
      if (release_now) begin
        gnt       <= 16'h0000;
        gnt_id    <= 4'd0;
        gnt_valid <= 1'b0;
        timeout   <= forced;
        hold_cnt  <= 8'd0;
        state     <= LIVRE;
      end else begin
        timeout  <= 1'b0;
        hold_cnt <= hold_cnt + 8'd1;
      end
    end
  end

endmodule
